// File: rtl/hid_pkg.sv
// Shared HID/USB constants for the keyboard-to-ASCII path: device type
// encodings, usage codes, modifier bit positions and the scan FSM states.
package hid_pkg;

    localparam logic [1:0] USB_TYP_NONE     = 2'd0;
    localparam logic [1:0] USB_TYP_KEYBOARD = 2'd1;
    localparam logic [1:0] USB_TYP_MOUSE    = 2'd2;
    localparam logic [1:0] USB_TYP_GAMEPAD  = 2'd3;

    localparam logic [7:0] HID_ROLLOVER       = 8'h01;
    localparam logic [7:0] HID_KEY_A          = 8'h04;
    localparam logic [7:0] HID_KEY_Z          = 8'h1D;
    localparam logic [7:0] HID_KEY_1          = 8'h1E;
    localparam logic [7:0] HID_KEY_0          = 8'h27;
    localparam logic [7:0] HID_KEY_ENTER      = 8'h28;
    localparam logic [7:0] HID_KEY_ESC        = 8'h29;
    localparam logic [7:0] HID_KEY_BKSP       = 8'h2A;
    localparam logic [7:0] HID_KEY_TAB        = 8'h2B;
    localparam logic [7:0] HID_KEY_SPACE      = 8'h2C;
    localparam logic [7:0] HID_KEY_MINUS      = 8'h2D;
    localparam logic [7:0] HID_KEY_NONUS_HASH = 8'h32;
    localparam logic [7:0] HID_KEY_SLASH      = 8'h38;
    localparam logic [7:0] HID_KEY_CAPS       = 8'h39;

    localparam int MOD_LCTRL_BIT  = 0;
    localparam int MOD_LSHIFT_BIT = 1;
    localparam int MOD_RCTRL_BIT  = 4;
    localparam int MOD_RSHIFT_BIT = 5;

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_BUSY = 1'b1
    } scan_state_e;

    // Four usage slots of a boot report; index 0 is key1.
    typedef logic [3:0][7:0] key_set_t;

    // True when any slot carries the ErrorRollOver code.
    function automatic logic has_rollover(input key_set_t keys);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keys[i] == HID_ROLLOVER) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/hid_usage_to_ascii.sv
// Combinational HID usage -> ASCII translation for a US layout.
// Letters use shift XOR caps for case, ctrl maps letters to 01-1A.
// Caps lock usage itself is never translatable.
module hid_usage_to_ascii
    import hid_pkg::*;
(
    input  logic [7:0] usage,
    input  logic       shift,
    input  logic       ctrl,
    input  logic       caps,
    output logic       valid,
    output logic [7:0] ascii
);

    logic [7:0] letter_ofs;
    logic       upper;

    assign letter_ofs = usage - HID_KEY_A;
    assign upper      = shift ^ caps;

    // Letters by arithmetic, everything else by table.
    always_comb begin
        valid = 1'b1;
        ascii = 8'h00;
        if (usage >= HID_KEY_A && usage <= HID_KEY_Z) begin
            if (ctrl) begin
                ascii = 8'h01 + letter_ofs;
            end else if (upper) begin
                ascii = 8'h41 + letter_ofs;
            end else begin
                ascii = 8'h61 + letter_ofs;
            end
        end else begin
            case (usage)
                HID_KEY_1:     ascii = shift ? 8'h21 : 8'h31;
                8'h1F:         ascii = shift ? 8'h40 : 8'h32;
                8'h20:         ascii = shift ? 8'h23 : 8'h33;
                8'h21:         ascii = shift ? 8'h24 : 8'h34;
                8'h22:         ascii = shift ? 8'h25 : 8'h35;
                8'h23:         ascii = shift ? 8'h5E : 8'h36;
                8'h24:         ascii = shift ? 8'h26 : 8'h37;
                8'h25:         ascii = shift ? 8'h2A : 8'h38;
                8'h26:         ascii = shift ? 8'h28 : 8'h39;
                HID_KEY_0:     ascii = shift ? 8'h29 : 8'h30;
                HID_KEY_ENTER: ascii = 8'h0D;
                HID_KEY_ESC:   ascii = 8'h1B;
                HID_KEY_BKSP:  ascii = 8'h08;
                HID_KEY_TAB:   ascii = 8'h09;
                HID_KEY_SPACE: ascii = 8'h20;
                HID_KEY_MINUS: ascii = shift ? 8'h5F : 8'h2D;
                8'h2E:         ascii = shift ? 8'h2B : 8'h3D;
                8'h2F:         ascii = shift ? 8'h7B : 8'h5B;
                8'h30:         ascii = shift ? 8'h7D : 8'h5D;
                8'h31:         ascii = shift ? 8'h7C : 8'h5C;
                8'h33:         ascii = shift ? 8'h3A : 8'h3B;
                8'h34:         ascii = shift ? 8'h22 : 8'h27;
                8'h35:         ascii = shift ? 8'h7E : 8'h60;
                8'h36:         ascii = shift ? 8'h3C : 8'h2C;
                8'h37:         ascii = shift ? 8'h3E : 8'h2E;
                HID_KEY_SLASH: ascii = shift ? 8'h3F : 8'h2F;
                default:       valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/hid_kbd_ascii.sv
// Keyboard report differ + ASCII FIFO. Snapshots each keyboard report,
// scans its four slots one per cycle against the previous report and
// pushes translated new presses into an inline FWFT FIFO.
// Optional feature macro: HID_KBD_CAPSLOCK_EN (caps lock toggling).
module hid_kbd_ascii
    import hid_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     usbclk,
    input  logic                     usbrst_n,
    input  logic [1:0]               typ,
    input  logic                     report,
    input  logic [7:0]               key_modifiers,
    input  logic [7:0]               key1,
    input  logic [7:0]               key2,
    input  logic [7:0]               key3,
    input  logic [7:0]               key4,
    output logic [7:0]               char_data,
    output logic                     char_valid,
    input  logic                     char_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     rpt_drop,
    output logic                     caps_lock
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    scan_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    key_set_t    snap_keys_q, snap_keys_d;
    key_set_t    prev_keys_q, prev_keys_d;
    key_set_t    in_keys;
    logic        snap_shift_q, snap_shift_d;
    logic        snap_ctrl_q, snap_ctrl_d;
    logic        rpt_drop_q, rpt_drop_d;
    logic        overflow_q, overflow_d;
    logic        caps_q, caps_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    fifo_mem_q [DEPTH];

    logic       is_kbd;
    logic       capture;
    logic [7:0] cur_key;
    logic       key_new;
    logic       xl_valid;
    logic [7:0] xl_ascii;
    logic       push_req;
    logic       pop;
    logic       full;
    logic       do_push;

    assign in_keys  = {key4, key3, key2, key1};
    assign is_kbd   = (typ == USB_TYP_KEYBOARD);
    assign capture  = (state_q == SCAN_IDLE) && report && is_kbd && !has_rollover(in_keys);
    assign cur_key  = snap_keys_q[idx_q];

    // A scanned key is new when it is nonzero and absent from the last report.
    always_comb begin
        key_new = (cur_key != 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (prev_keys_q[i] == cur_key) begin
                key_new = 1'b0;
            end
        end
    end

    hid_usage_to_ascii u_xlate (
        .usage (cur_key),
        .shift (snap_shift_q),
        .ctrl  (snap_ctrl_q),
        .caps  (caps_q),
        .valid (xl_valid),
        .ascii (xl_ascii)
    );

    assign push_req   = (state_q == SCAN_BUSY) && key_new && xl_valid;
    assign char_valid = (count_q != '0);
    assign pop        = char_valid && char_ready;
    assign full       = (count_q == FULL_LEVEL);
    assign do_push    = push_req && (!full || pop);

    // Scan FSM next state: capture a snapshot, walk four slots, then commit it as prev.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_keys_d  = snap_keys_q;
        snap_shift_d = snap_shift_q;
        snap_ctrl_d  = snap_ctrl_q;
        prev_keys_d  = prev_keys_q;
        rpt_drop_d   = rpt_drop_q;
        case (state_q)
            SCAN_IDLE: begin
                if (capture) begin
                    state_d      = SCAN_BUSY;
                    idx_d        = 2'd0;
                    snap_keys_d  = in_keys;
                    snap_shift_d = key_modifiers[MOD_LSHIFT_BIT] | key_modifiers[MOD_RSHIFT_BIT];
                    snap_ctrl_d  = key_modifiers[MOD_LCTRL_BIT] | key_modifiers[MOD_RCTRL_BIT];
                end
            end
            SCAN_BUSY: begin
                if (report) begin
                    rpt_drop_d = 1'b1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d     = SCAN_IDLE;
                    prev_keys_d = snap_keys_q;
                end
            end
        endcase
        if (!is_kbd) begin
            prev_keys_d = '0;
        end
    end

    // Caps lock state toggles on each newly pressed caps key when enabled.
    always_comb begin
        caps_d = caps_q;
`ifdef HID_KBD_CAPSLOCK_EN
        if (state_q == SCAN_BUSY && key_new && cur_key == HID_KEY_CAPS) begin
            caps_d = ~caps_q;
        end
`else
        caps_d = 1'b0;
`endif
    end

    // FIFO pointer/occupancy update; a full push without a pop is dropped.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control and status registers.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            state_q      <= SCAN_IDLE;
            idx_q        <= 2'd0;
            snap_keys_q  <= '0;
            snap_shift_q <= 1'b0;
            snap_ctrl_q  <= 1'b0;
            prev_keys_q  <= '0;
            rpt_drop_q   <= 1'b0;
            overflow_q   <= 1'b0;
            caps_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_keys_q  <= snap_keys_d;
            snap_shift_q <= snap_shift_d;
            snap_ctrl_q  <= snap_ctrl_d;
            prev_keys_q  <= prev_keys_d;
            rpt_drop_q   <= rpt_drop_d;
            overflow_q   <= overflow_d;
            caps_q       <= caps_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; cleared on reset so char_data reads 0 out of reset.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= 8'h00;
            end
        end else if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= xl_ascii;
        end
    end

    assign char_data  = fifo_mem_q[rd_ptr_q];
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign rpt_drop   = rpt_drop_q;
    assign caps_lock  = caps_q;

endmodule

// File: tb/tb_hid_kbd_ascii.sv
// Directed bench for hid_kbd_ascii with a byte scoreboard.
// Optional feature macro: HID_KBD_CAPSLOCK_EN changes the caps lock expectations.
module tb_hid_kbd_ascii;

    localparam int DEPTH = 16;

    logic       usbclk = 1'b0;
    logic       usbrst_n = 1'b0;
    logic [1:0] typ = 2'd1;
    logic       report = 1'b0;
    logic [7:0] key_modifiers = 8'h00;
    logic [7:0] key1 = 8'h00;
    logic [7:0] key2 = 8'h00;
    logic [7:0] key3 = 8'h00;
    logic [7:0] key4 = 8'h00;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready = 1'b1;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       rpt_drop;
    logic       caps_lock;

    int         n_compared = 0;
    int         n_mismatched = 0;
    logic [7:0] sb_q [$];
    bit         mon_en = 1'b0;

    always #5 usbclk = ~usbclk;

    hid_kbd_ascii #(.DEPTH(DEPTH)) dut (
        .usbclk        (usbclk),
        .usbrst_n      (usbrst_n),
        .typ           (typ),
        .report        (report),
        .key_modifiers (key_modifiers),
        .key1          (key1),
        .key2          (key2),
        .key3          (key3),
        .key4          (key4),
        .char_data     (char_data),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .rpt_drop      (rpt_drop),
        .caps_lock     (caps_lock)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one report pulse; returns one ns into the cycle after the pulse.
    task automatic applyStimulus(input logic [1:0] t, input logic [7:0] mods,
                                 input logic [7:0] k1, input logic [7:0] k2,
                                 input logic [7:0] k3, input logic [7:0] k4);
        @(posedge usbclk);
        #1;
        typ = t;
        key_modifiers = mods;
        key1 = k1;
        key2 = k2;
        key3 = k3;
        key4 = k4;
        report = 1'b1;
        @(posedge usbclk);
        #1;
        report = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge usbclk);
        #1;
    endtask

    task automatic releaseAll();
        applyStimulus(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        idle(6);
    endtask

    task automatic waitDrain(input int max_cycles);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || char_valid) && k < max_cycles) begin
            @(negedge usbclk);
            k++;
        end
        n_compared++;
        assert (sb_q.size() == 0 && !char_valid) else begin
            n_mismatched++;
            $error("[TB] FAIL drain observed=%0d pending expected=0 pending", sb_q.size());
        end
    endtask

    // Scoreboard: every byte the sink accepts must be the oldest expected byte.
    always @(negedge usbclk) begin
        logic [7:0] exp_byte;
        if (mon_en && usbrst_n && char_valid && char_ready) begin
            n_compared++;
            assert (sb_q.size() != 0) else begin
                n_mismatched++;
                $error("[TB] FAIL unexpected_char observed=%h expected=none", char_data);
            end
            if (sb_q.size() != 0) begin
                exp_byte = sb_q.pop_front();
                checkOutput("char_data", char_data, exp_byte);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge usbclk);
        checkOutput("rst_valid", {7'd0, char_valid}, 8'h00);
        checkOutput("rst_level", {3'd0, fifo_level}, 8'h00);
        checkOutput("rst_overflow", {7'd0, overflow}, 8'h00);
        checkOutput("rst_rpt_drop", {7'd0, rpt_drop}, 8'h00);
        checkOutput("rst_caps", {7'd0, caps_lock}, 8'h00);
        checkOutput("rst_data", char_data, 8'h00);
        usbrst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Single press, then an identical report produces nothing
        sb_q.push_back(8'h61);
        applyStimulus(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        idle(6);
        applyStimulus(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        idle(6);
        waitDrain(50);
        releaseAll();

        // Shifted multi-key report with latency check
        sb_q.push_back(8'h41);
        sb_q.push_back(8'h42);
        sb_q.push_back(8'h43);
        applyStimulus(2'd1, 8'h02, 8'h04, 8'h05, 8'h06, 8'h00);
        @(negedge usbclk);
        checkOutput("lat_t1_valid", {7'd0, char_valid}, 8'h00);
        @(negedge usbclk);
        checkOutput("lat_t2_valid", {7'd0, char_valid}, 8'h01);
        idle(6);
        waitDrain(50);
        releaseAll();

        // Rollover report ignored; only the newly added key emits
        sb_q.push_back(8'h31);
        applyStimulus(2'd1, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00);
        idle(6);
        applyStimulus(2'd1, 8'h00, 8'h1E, 8'h01, 8'h00, 8'h00);
        idle(6);
        sb_q.push_back(8'h32);
        applyStimulus(2'd1, 8'h00, 8'h1E, 8'h1F, 8'h00, 8'h00);
        idle(6);
        waitDrain(50);
        releaseAll();

        // Ctrl letter, punctuation with an untranslatable slot, right shift
        sb_q.push_back(8'h01);
        applyStimulus(2'd1, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00);
        idle(6);
        releaseAll();
        sb_q.push_back(8'h2D);
        sb_q.push_back(8'h5C);
        sb_q.push_back(8'h20);
        applyStimulus(2'd1, 8'h00, 8'h2D, 8'h31, 8'h32, 8'h2C);
        idle(6);
        releaseAll();
        sb_q.push_back(8'h5F);
        sb_q.push_back(8'h21);
        sb_q.push_back(8'h0D);
        applyStimulus(2'd1, 8'h20, 8'h2D, 8'h1E, 8'h28, 8'h00);
        idle(6);
        waitDrain(50);
        releaseAll();
        checkOutput("pre_overflow", {7'd0, overflow}, 8'h00);

        // Overflow: DEPTH+3 presses with the sink stalled
        char_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) begin
                sb_q.push_back(8'h61 + 8'(i));
            end
            applyStimulus(2'd1, 8'h00, 8'h04 + 8'(i), 8'h00, 8'h00, 8'h00);
            idle(5);
        end
        @(negedge usbclk);
        checkOutput("full_level", {3'd0, fifo_level}, 8'(DEPTH));
        checkOutput("overflow_set", {7'd0, overflow}, 8'h01);
        @(posedge usbclk);
        #1;
        char_ready = 1'b1;
        waitDrain(100);
        releaseAll();

        // Typ drop clears history; back-to-back report is dropped
        sb_q.push_back(8'h61);
        applyStimulus(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        idle(6);
        waitDrain(50);
        typ = 2'd0;
        idle(3);
        typ = 2'd1;
        checkOutput("pre_rpt_drop", {7'd0, rpt_drop}, 8'h00);
        sb_q.push_back(8'h61);
        applyStimulus(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        @(posedge usbclk);
        #1;
        report = 1'b1;
        @(posedge usbclk);
        #1;
        report = 1'b0;
        idle(6);
        checkOutput("rpt_drop_set", {7'd0, rpt_drop}, 8'h01);
        waitDrain(50);
        releaseAll();

        // Caps lock press, release, then shifted letter
        applyStimulus(2'd1, 8'h00, 8'h39, 8'h00, 8'h00, 8'h00);
        idle(6);
        releaseAll();
`ifdef HID_KBD_CAPSLOCK_EN
        sb_q.push_back(8'h61);
`else
        sb_q.push_back(8'h41);
`endif
        applyStimulus(2'd1, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
        idle(6);
        waitDrain(50);
`ifdef HID_KBD_CAPSLOCK_EN
        checkOutput("caps_lock", {7'd0, caps_lock}, 8'h01);
`else
        checkOutput("caps_lock", {7'd0, caps_lock}, 8'h00);
`endif

        idle(2);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
